// File: rtl/ce_serializer.sv
// -----------------------------------------------------------------------------
// ce_serializer
//
// Transmit-side driver for a CE-qualified capture flop. A parallel word is
// accepted over a valid/ready handshake and shifted out one bit at a time on
// D. Every bit is held for DIV cycles. CE strobes for one cycle in the last
// cycle of each bit period, so a downstream flop clocked on CK and enabled by
// CE captures exactly one bit per strobe.
//
// Parameters:
//   WIDTH     bits per word (>= 1)
//   DIV       clock cycles per bit period (>= 2)
//   MSB_FIRST "TRUE": bit WIDTH-1 goes first, "FALSE": bit 0 goes first
//
// Ports:
//   CK       in   clock, rising edge
//   SR       in   synchronous active-high reset
//   data_in  in   word to send, sampled only on the accept edge
//   valid    in   producer has a word
//   ready    out  idle and able to accept a word
//   D        out  serial data, stable for the whole bit period
//   CE       out  one-cycle strobe in the last cycle of each bit period
//   busy     out  frame in progress
//   done     out  one-cycle pulse after the last bit period
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module ce_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DIV       = 4,
   parameter string       MSB_FIRST = "TRUE"
) (
   input  logic             CK,
   input  logic             SR,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid,
   output logic             ready,
   output logic             D,
   output logic             CE,
   output logic             busy,
   output logic             done
);

   localparam int unsigned BIT_W = $clog2(WIDTH + 1);
   localparam int unsigned DIV_W = $clog2(DIV);
   localparam bit          LP_MSB = (MSB_FIRST == "TRUE");
   localparam logic [DIV_W-1:0] LP_DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [BIT_W-1:0] LP_BIT_LAST = BIT_W'(WIDTH - 1);

   // Reject unusable configurations at elaboration time.
   generate
      if (DIV < 2) begin : g_bad_div
         $error("ce_serializer: DIV must be >= 2");
      end
      if (WIDTH < 1) begin : g_bad_width
         $error("ce_serializer: WIDTH must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   state_e           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [DIV_W-1:0] r_div;
   logic [BIT_W-1:0] r_bit;
   logic             r_ready;
   logic             r_d;
   logic             r_ce;
   logic             r_busy;
   logic             r_done;

   logic             w_accept;
   logic             w_first_bit;
   logic [WIDTH-1:0] w_shift_nxt;
   logic             w_next_bit;
   logic             w_div_last;
   logic             w_bit_last;
   logic [DIV_W-1:0] w_div_inc;

   // A producer still holding valid during the DONE cycle is taken on the edge
   // that ends it, which spaces back-to-back frames by exactly one idle cycle.
   // In IDLE, ready must already be high (it is low for the first cycle after
   // reset).
   assign w_accept = valid && (((r_state == StIdle) && r_ready) || (r_state == StDone));

   // The bit about to be presented always sits at the outgoing end of the
   // shift register, so both orders share one shift-and-pick path.
   assign w_first_bit = LP_MSB ? data_in[WIDTH-1] : data_in[0];
   assign w_shift_nxt = LP_MSB ? (r_shift << 1) : (r_shift >> 1);
   assign w_next_bit  = LP_MSB ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];

   assign w_div_last = (r_div == LP_DIV_LAST);
   assign w_bit_last = (r_bit == LP_BIT_LAST);
   assign w_div_inc  = r_div + DIV_W'(1);

   always_ff @(posedge CK) begin
      if (SR) begin
         r_state <= StIdle;
         r_shift <= '0;
         r_div   <= '0;
         r_bit   <= '0;
         r_ready <= 1'b0;
         r_d     <= 1'b0;
         r_ce    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (w_accept) begin
         r_state <= StShift;
         r_shift <= data_in;
         r_d     <= w_first_bit;
         r_div   <= '0;
         r_bit   <= '0;
         r_ce    <= 1'b0;
         r_busy  <= 1'b1;
         r_ready <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_ready <= 1'b1;
               r_done  <= 1'b0;
            end

            StShift: begin
               if (w_div_last) begin
                  // Edge closing a CE cycle: the current bit has been captured.
                  r_div <= '0;
                  r_ce  <= 1'b0;
                  if (w_bit_last) begin
                     r_state <= StDone;
                     r_busy  <= 1'b0;
                     r_d     <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_bit   <= r_bit + BIT_W'(1);
                     r_shift <= w_shift_nxt;
                     r_d     <= w_next_bit;
                  end
               end else begin
                  r_div <= w_div_inc;
                  // CE is registered, so raise it on the edge that enters the
                  // last cycle of the bit period.
                  r_ce  <= (w_div_inc == LP_DIV_LAST);
               end
            end

            StDone: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= StIdle;
            end

            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
               r_ce    <= 1'b0;
               r_d     <= 1'b0;
               r_done  <= 1'b0;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign ready = r_ready;
   assign D     = r_d;
   assign CE    = r_ce;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule

// File: tb/tb_ce_serializer.sv
// -----------------------------------------------------------------------------
// tb_ce_serializer
//
// Drives one MSB-first and one LSB-first ce_serializer (WIDTH=8, DIV=4) with
// the same directed stimulus. A frame-level model (cycles elapsed since the
// accept edge) predicts every output on every cycle; hand-computed literals
// pin strobe positions, done timing and the captured words.
// -----------------------------------------------------------------------------
module tb_ce_serializer;

   localparam int W  = 8;
   localparam int DV = 4;
   localparam int FL = W * DV;

   logic         CK = 1'b0;
   logic         SR = 1'b1;
   logic         valid = 1'b0;
   logic [W-1:0] data_in = '0;

   logic ready0, d0, ce0, busy0, done0;
   logic ready1, d1, ce1, busy1, done1;

   ce_serializer #(.WIDTH(W), .DIV(DV), .MSB_FIRST("TRUE")) u_msb (
      .CK(CK), .SR(SR), .data_in(data_in), .valid(valid),
      .ready(ready0), .D(d0), .CE(ce0), .busy(busy0), .done(done0)
   );

   ce_serializer #(.WIDTH(W), .DIV(DV), .MSB_FIRST("FALSE")) u_lsb (
      .CK(CK), .SR(SR), .data_in(data_in), .valid(valid),
      .ready(ready1), .D(d1), .CE(ce1), .busy(busy1), .done(done1)
   );

   always #5 CK = ~CK;

   int cyc = 0;
   always @(posedge CK) cyc <= cyc + 1;

   int n_pass = 0;
   int n_tot  = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
   endtask

   // Frame model: m_t counts cycles since the accept edge (-1 when no frame).
   int           m_t = -1;
   logic [W-1:0] m_word = '0;
   bit           m_rdy = 1'b0;

   always @(posedge CK) begin
      if (SR) begin
         m_t   = -1;
         m_rdy = 1'b0;
      end else if (valid && (m_rdy || m_t == FL)) begin
         m_word = data_in;
         m_t    = 0;
         m_rdy  = 1'b0;
      end else if (m_t >= 0 && m_t < FL) begin
         m_t++;
      end else begin
         m_t   = -1;
         m_rdy = 1'b1;
      end
   end

   // Per-cycle compare against the model.
   bit e_busy, e_ce, e_d0, e_d1;
   int e_k;
   always @(negedge CK) begin
      if (chk_en) begin
         e_busy = (m_t >= 0 && m_t < FL);
         e_ce   = e_busy && (m_t % DV == DV - 1);
         e_d0   = 1'b0;
         e_d1   = 1'b0;
         if (e_busy) begin
            e_k  = m_t / DV;
            e_d0 = m_word[W-1-e_k];
            e_d1 = m_word[e_k];
         end
         chk("msb.ready", ready0, m_rdy);
         chk("msb.busy", busy0, e_busy);
         chk("msb.CE", ce0, e_ce);
         chk("msb.D", d0, e_d0);
         chk("msb.done", done0, m_t == FL);
         chk("lsb.ready", ready1, m_rdy);
         chk("lsb.busy", busy1, e_busy);
         chk("lsb.CE", ce1, e_ce);
         chk("lsb.D", d1, e_d1);
         chk("lsb.done", done1, m_t == FL);
      end
   end

   // Downstream capture: D is sampled in every CE cycle.
   int ce_q0[$];
   int done_q0[$];
   bit bits0[$];
   bit bits1[$];
   always @(negedge CK) begin
      if (ce0) begin
         ce_q0.push_back(cyc);
         bits0.push_back(d0);
      end
      if (ce1) bits1.push_back(d1);
      if (done0) done_q0.push_back(cyc);
   end

   function automatic logic [15:0] pack_msb(input bit q[$]);
      logic [15:0] w = '0;
      foreach (q[i]) w = {w[14:0], q[i]};
      return w;
   endfunction

   function automatic logic [15:0] pack_lsb(input bit q[$]);
      logic [15:0] w = '0;
      foreach (q[i]) if (i < 16) w[i] = q[i];
      return w;
   endfunction

   task automatic clear_logs();
      ce_q0.delete();
      done_q0.delete();
      bits0.delete();
      bits1.delete();
   endtask

   // Returns 1 time unit after the negedge following edge 'target'.
   task automatic wait_cyc(input int target);
      do @(negedge CK); while (cyc < target);
      #1;
   endtask

   int n;

   initial begin
      // 1: reset with valid held high.
      SR = 1'b1; valid = 1'b1; data_in = 8'hFF;
      @(posedge CK);
      chk_en = 1'b1;
      repeat (2) @(posedge CK);
      wait_cyc(cyc);
      chk("rst.ready", ready0, 1'b0);
      chk("rst.busy", busy0, 1'b0);
      SR = 1'b0; valid = 1'b0;
      n = cyc + 1;
      wait_cyc(n);
      chk("rst.ready_rise.msb", ready0, 1'b1);
      chk("rst.ready_rise.lsb", ready1, 1'b1);

      // 2: single frame 8'hA5, MSB first.
      clear_logs();
      data_in = 8'hA5; valid = 1'b1; n = cyc + 1;
      wait_cyc(n);
      valid = 1'b0;
      wait_cyc(n + FL);
      chk("a5.done_edge", done0, 1'b1);
      wait_cyc(n + FL + 1);
      chk("a5.ready_back", ready0, 1'b1);
      chk("a5.ce_count", ce_q0.size(), 8);
      chk("a5.first_ce", ce_q0[0], n + 3);
      chk("a5.last_ce", ce_q0[7], n + 31);
      chk("a5.capture", pack_msb(bits0), 16'h00A5);

      // 3: 8'h01, LSB-first instance.
      clear_logs();
      data_in = 8'h01; valid = 1'b1; n = cyc + 1;
      wait_cyc(n);
      chk("01.lsb_first_bit", d1, 1'b1);
      valid = 1'b0;
      wait_cyc(n + FL + 1);
      chk("01.lsb_ce_count", bits1.size(), 8);
      chk("01.lsb_capture", pack_lsb(bits1), 16'h0001);
      chk("01.msb_capture", pack_msb(bits0), 16'h0001);

      // 4: back-to-back 8'hFF then 8'h00 with valid held.
      clear_logs();
      data_in = 8'hFF; valid = 1'b1; n = cyc + 1;
      wait_cyc(n);
      data_in = 8'h00;
      wait_cyc(n + FL + 1);
      chk("b2b.second_accept", busy0, 1'b1);
      valid = 1'b0;
      wait_cyc(n + 2 * FL + 3);
      chk("b2b.ce_count", ce_q0.size(), 16);
      chk("b2b.gap", ce_q0[8] - ce_q0[7], DV + 1);
      chk("b2b.second_first_ce", ce_q0[8], n + FL + 1 + 3);
      chk("b2b.capture", pack_msb(bits0), 16'hFF00);
      chk("b2b.done_count", done_q0.size(), 2);

      // 5: reset at edge n+13 of a frame.
      clear_logs();
      data_in = 8'h5A; valid = 1'b1; n = cyc + 1;
      wait_cyc(n);
      valid = 1'b0;
      wait_cyc(n + 12);
      SR = 1'b1;
      wait_cyc(n + 13);
      chk("mid.CE", ce0, 1'b0);
      chk("mid.D", d0, 1'b0);
      chk("mid.busy", busy0, 1'b0);
      SR = 1'b0;
      wait_cyc(n + 45);
      chk("mid.no_done", done_q0.size(), 0);
      chk("mid.partial_ce", ce_q0.size(), 3);
      clear_logs();
      data_in = 8'hC3; valid = 1'b1; n = cyc + 1;
      wait_cyc(n);
      valid = 1'b0;
      wait_cyc(n + FL + 1);
      chk("mid.after_capture", pack_msb(bits0), 16'h00C3);
      chk("mid.after_done", done_q0.size(), 1);

      // 6: valid pulse during a frame is ignored.
      clear_logs();
      data_in = 8'h3C; valid = 1'b1; n = cyc + 1;
      wait_cyc(n);
      valid = 1'b0;
      wait_cyc(n + 10);
      data_in = 8'hFF; valid = 1'b1;
      wait_cyc(n + 11);
      valid = 1'b0;
      wait_cyc(n + FL + 12);
      chk("ign.capture", pack_msb(bits0), 16'h003C);
      chk("ign.ce_count", ce_q0.size(), 8);
      chk("ign.done_count", done_q0.size(), 1);
      chk("ign.idle", ready0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
